// File: rtl/tinysoc_pkg.sv
// tinysoc_pkg: shared loader defaults, state encoding and configuration check.
package tinysoc_pkg;

   localparam int CHUNK_W_DEF = 4;
   localparam int WORD_W_DEF  = 16;
   localparam int DEPTH_DEF   = 16;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } ld_state_e;

   // A word must split into at least two whole chunks for the shift register to exist.
   function automatic bit chunks_fit(input int word_w, input int chunk_w);
      return chunk_w > 0 && word_w % chunk_w == 0 && word_w / chunk_w >= 2;
   endfunction

endpackage

// File: rtl/chunk_assembler.sv
// chunk_assembler: gathers little-endian chunks into one word, valid with the final chunk.
module chunk_assembler #(
   parameter int CHUNK_W = 4,
   parameter int WORD_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               accept,
   input  logic [CHUNK_W-1:0] in_data,
   output logic               word_valid,
   output logic [WORD_W-1:0]  word
);

   localparam int CHUNKS = WORD_W / CHUNK_W;
   localparam int CNT_W  = $clog2(CHUNKS);
   localparam int SH_W   = WORD_W - CHUNK_W;

   logic [CNT_W-1:0] cnt;
   logic [SH_W-1:0]  sh;
   logic             last;

   assign last       = cnt == CNT_W'(CHUNKS - 1);
   assign word_valid = accept && last;
   assign word       = {in_data, sh};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sh  <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= last ? '0 : cnt + 1'b1;
         if (!last) sh[cnt*CHUNK_W +: CHUNK_W] <= in_data;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams chunks into sequential instruction memory writes, then verifies an XOR checksum.
module prog_loader
   import tinysoc_pkg::*;
#(
   parameter int CHUNK_W = CHUNK_W_DEF,
   parameter int WORD_W  = WORD_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   input  logic [CHUNK_W-1:0] in_data,
   output logic               in_ready,
   output logic               mem_wr,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [WORD_W-1:0]  mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               cpu_en
);

   if (!chunks_fit(WORD_W, CHUNK_W)) begin : g_bad_chunks
      $error("prog_loader: WORD_W must be a multiple (at least 2x) of CHUNK_W");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("prog_loader: DEPTH must be at least 2");
   end

   ld_state_e         state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] csum, word;
   logic              accept, word_valid, clr, last_addr, load_wr;

   assign busy      = state == LOAD || state == CHECK;
   assign in_ready  = busy;
   assign cpu_en    = done;
   assign accept    = in_valid && in_ready;
   assign clr       = start && !busy;
   assign last_addr = addr == ADDR_W'(DEPTH - 1);
   assign load_wr   = word_valid && state == LOAD;

   chunk_assembler #(.CHUNK_W(CHUNK_W), .WORD_W(WORD_W)) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .accept    (accept),
      .in_data   (in_data),
      .word_valid(word_valid),
      .word      (word)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:    state_nxt = load_wr && last_addr ? CHECK : LOAD;
         CHECK:   state_nxt = !word_valid ? CHECK : (word == csum ? DONE : ERROR);
         default: state_nxt = start ? LOAD : state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         addr      <= '0;
         csum      <= '0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state  <= state_nxt;
         mem_wr <= load_wr;
         done   <= state_nxt == DONE;
         err    <= state_nxt == ERROR;
         if (clr) begin
            csum <= '0;
            addr <= '0;
         end else if (load_wr) begin
            mem_addr  <= addr;
            mem_wdata <= word;
            csum      <= csum ^ word;
            addr      <= last_addr ? '0 : addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader, default and 8/24/4 parameter sets.
module tb_prog_loader;

   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [3:0]  in_data = '0;
   logic        in_ready, mem_wr, busy, done, err, cpu_en;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;

   logic        start2 = 1'b0, in_valid2 = 1'b0;
   logic [7:0]  in_data2 = '0;
   logic        in_ready2, mem_wr2, busy2, done2, err2, cpu_en2;
   logic [1:0]  mem_addr2;
   logic [23:0] mem_wdata2;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t q1[$], q2[$];
   int  ncyc = 0, errors = 0, checks = 0, exp_addr = 0, exp_addr2 = 0;

   always #5 clk = ~clk;

   prog_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .cpu_en(cpu_en)
   );

   prog_loader #(.CHUNK_W(8), .WORD_W(24), .DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .busy(busy2), .done(done2), .err(err2), .cpu_en(cpu_en2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      ncyc++;
      if (mem_wr === 1'b1) begin
         if (q1.size() == 0) check("wr1_unexpected", 1, 0);
         else begin
            e = q1.pop_front();
            check("wr1_latency", ncyc, e.cyc + 1);
            check("wr1_addr", 32'(mem_addr), e.addr);
            check("wr1_data", 32'(mem_wdata), e.data);
         end
      end
      if (mem_wr2 === 1'b1) begin
         if (q2.size() == 0) check("wr2_unexpected", 1, 0);
         else begin
            e = q2.pop_front();
            check("wr2_latency", ncyc, e.cyc + 1);
            check("wr2_addr", 32'(mem_addr2), e.addr);
            check("wr2_data", 32'(mem_wdata2), e.data);
         end
      end
   end

   task automatic send1(input logic [3:0] d, input bit push, input logic [15:0] w);
      int  t = 0;
      wr_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("rdy1_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) begin
         e.cyc  = ncyc;
         e.addr = exp_addr;
         e.data = {16'h0, w};
         q1.push_back(e);
         exp_addr = (exp_addr + 1) % 16;
      end
   endtask

   task automatic gap1(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic word1(input logic [15:0] w, input bit push, input int gap_pct);
      for (int k = 0; k < 4; k++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) gap1($urandom_range(1, 3));
         send1(w[k*4 +: 4], push && k == 3, w);
      end
   endtask

   task automatic load1(input logic [15:0] ws[16], input logic [15:0] cs, input int gap_pct);
      for (int i = 0; i < 16; i++) word1(ws[i], 1'b1, gap_pct);
      word1(cs, 1'b0, gap_pct);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic restart1();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_addr = 0;
      check("restart_busy", busy, 1);
      check("restart_done_clr", done | err, 0);
   endtask

   task automatic send2(input logic [7:0] d, input bit push, input logic [23:0] w);
      int  t = 0;
      wr_t e;
      @(negedge clk);
      in_valid2 = 1'b1;
      in_data2  = d;
      while (!in_ready2 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready2) begin
         check("rdy2_timeout", 0, 1);
         in_valid2 = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) begin
         e.cyc  = ncyc;
         e.addr = exp_addr2;
         e.data = {8'h0, w};
         q2.push_back(e);
         exp_addr2 = (exp_addr2 + 1) % 4;
      end
   endtask

   task automatic word2(input logic [23:0] w, input bit push);
      for (int k = 0; k < 3; k++) send2(w[k*8 +: 8], push && k == 2, w);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] ws[16];
      logic [15:0] cs;
      logic [23:0] w2[4];
      logic [23:0] cs2;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_ready", in_ready, 1);
      check("rst_wr", mem_wr, 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_done_err", {done, err, cpu_en}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) ws[i] = 16'(i);
      load1(ws, 16'h0000, 0);
      check("t1_done", done, 1);
      check("t1_cpu_en", cpu_en, 1);
      check("t1_err", err, 0);
      check("t1_ready", in_ready, 0);
      check("t1_busy", busy, 0);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check("t1_hold_done", done, 1);
      check("t1_pending", q1.size(), 0);

      restart1();
      load1(ws, 16'h0001, 0);
      check("t2_err", err, 1);
      check("t2_done", done, 0);
      check("t2_cpu_en", cpu_en, 0);
      check("t2_ready", in_ready, 0);

      restart1();
      ws[0] = 16'h4321;
      cs = ws[0];
      for (int i = 1; i < 16; i++) begin
         ws[i] = 16'($urandom);
         cs ^= ws[i];
      end
      load1(ws, cs, 50);
      check("t3_done", done, 1);
      check("t3_err", err, 0);

      restart1();
      for (int i = 0; i < 16; i++) ws[i] = 16'hFFFF;
      load1(ws, 16'h0000, 0);
      check("t4_done", done, 1);

      restart1();
      for (int i = 0; i < 5; i++) word1(16'(i), 1'b1, 0);
      send1(4'h5, 1'b0, 16'h5);
      send1(4'h0, 1'b0, 16'h5);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5_rst_wr", mem_wr, 0);
      check("t5_rst_addr", 32'(mem_addr), 0);
      check("t5_rst_wdata", 32'(mem_wdata), 0);
      check("t5_rst_busy", busy, 1);
      check("t5_rst_done_err", {done, err}, 0);
      check("t5_pending", q1.size(), 0);
      exp_addr = 0;
      exp_addr2 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) ws[i] = 16'(i);
      load1(ws, 16'h0000, 0);
      check("t5_done", done, 1);

      w2[0] = 24'hCCBBAA;
      cs2 = w2[0];
      for (int i = 1; i < 4; i++) begin
         w2[i] = 24'($urandom);
         cs2 ^= w2[i];
      end
      send2(8'hAA, 1'b0, w2[0]);
      send2(8'hBB, 1'b0, w2[0]);
      send2(8'hCC, 1'b1, w2[0]);
      for (int i = 1; i < 4; i++) word2(w2[i], 1'b1);
      @(negedge clk);
      in_valid2 = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_check_busy", busy2, 1);
      check("t6_check_ready", in_ready2, 1);
      check("t6_check_nodone", done2, 0);
      check("t6_pending", q2.size(), 0);
      word2(cs2, 1'b0);
      @(negedge clk);
      in_valid2 = 1'b0;
      check("t6_done", done2, 1);
      check("t6_err", err2, 0);

      repeat (3) @(negedge clk);
      check("end_q1_empty", q1.size(), 0);
      check("end_q2_empty", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised streaming program loader; successor to the fixed 4-bit-nibble/16-word instruction ROM fill logic in tinysoc.
- Assembles CHUNK_W-bit input chunks into WORD_W-bit words and writes them sequentially into a DEPTH-entry instruction memory.
- Adds what the previous loader lacked: valid/ready handshake, XOR checksum verification, restart without reset, and a run-enable for the CPU.

Parameters:
- CHUNK_W, 4, width of one input chunk.
- WORD_W, 16, instruction word width. Must be an integer multiple of CHUNK_W.
- DEPTH, 16, number of words to load. Must be ≥2.
- ADDR_W, $clog2(DEPTH), memory address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  restart-load pulse; honoured only in DONE or ERROR.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  CHUNK_W  input chunk.
- in_ready  out  1  loader accepts a chunk this cycle.
- mem_wr  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  WORD_W  write data.
- busy  out  1  in LOAD or CHECK.
- done  out  1  load finished, checksum matched.
- err  out  1  load finished, checksum mismatch.
- cpu_en  out  1  equals done; drives CPU enable.

Behaviour:
- Constant: CHUNKS = WORD_W/CHUNK_W.
- Registered state:
  - FSM: LOAD, CHECK, DONE, ERROR.
  - chunk counter, 0..CHUNKS-1.
  - word address, 0..DEPTH-1.
  - shift register holding the first CHUNKS-1 chunks.
  - running XOR checksum, WORD_W bits.
- Reset (rst_n low, async): state LOAD, counters 0, shift register 0, checksum 0, mem_wr 0, mem_addr 0, mem_wdata 0, done 0, err 0. busy is 1 after reset; loading starts automatically.
- Handshake:
  - in_ready = 1 in LOAD and CHECK, 0 otherwise.
  - A chunk is accepted when in_valid && in_ready.
  - No acceptance means no state change; stalls of any length are allowed.
- Chunk order is little-endian: chunk k fills bits [k*CHUNK_W +: CHUNK_W].
- LOAD, on accepting chunk CHUNKS-1:
  - Next cycle: mem_wr = 1, mem_addr = current word address, mem_wdata = {in_data, shift register}. Latency is 1 cycle from final-chunk acceptance.
  - mem_wr is 1 for exactly one cycle per word.
  - checksum ^= assembled word; chunk counter clears.
  - If address == DEPTH-1: go to CHECK, address wraps to 0. Otherwise address increments.
- CHECK:
  - Accepts one further word, CHUNKS chunks: the expected checksum. No memory write.
  - On its final chunk: go to DONE if word == running checksum, else ERROR.
  - done/err are registered and assert the cycle after that final chunk.
- DONE and ERROR:
  - in_ready = 0; input is ignored.
  - start high: clear done, err, checksum and counters; go to LOAD next cycle.
  - start in LOAD or CHECK is ignored. A mid-load restart requires rst_n.
- Outputs: busy = (state==LOAD||state==CHECK); cpu_en = done. done and err are never both 1.
- Async reset mid-operation abandons the partial word. Memory contents are untouched; the loader restarts at address 0.
- Back-to-back words: a new chunk may be accepted in the same cycle mem_wr is high (full throughput, one chunk per cycle).

Decomposition:
- Shared package (tinysoc_pkg): CHUNK_W/WORD_W/DEPTH defaults, state encoding (LOAD=2'd0, CHECK=2'd1, DONE=2'd2, ERROR=2'd3), and the WORD_W % CHUNK_W elaboration check.
- One natural sub-module: chunk_assembler. It holds the chunk counter and shift register, and outputs word_valid and word. The FSM, address and checksum stay in prog_loader.

Test Plan:
- Release rst_n; stream 64 chunks encoding words 16'h0000..16'h000F, in_valid=1 continuously, then checksum chunks for 16'h0000 (XOR of 0..15) -> 16 mem_wr pulses, addr 0..15, each 1 cycle after 4th chunk; done=1, cpu_en=1, err=0, in_ready=0.
- Same stream but checksum 16'h0001 -> err=1, done=0, cpu_en=0; no 17th mem_wr.
- Random in_valid gaps (50%), chunks 4'h1,4'h2,4'h3,4'h4 -> mem_wdata=16'h4321 at addr 0; no write during stalls.
- After DONE, pulse start; reload 16 words of 16'hFFFF with checksum 16'h0000 -> busy reasserts next cycle, writes restart at addr 0, done=1 at end.
- Assert rst_n low after 2 chunks of word 5 -> all outputs reset immediately; next load writes word 0 at addr 0.
- Parameter set CHUNK_W=8, WORD_W=24, DEPTH=4: chunks 8'hAA,8'hBB,8'hCC -> mem_wdata=24'hCCBBAA; 4 writes then CHECK.
